// File: rtl/flatten_ibuf_tx.sv
// flatten_ibuf_tx: buffers upstream pixel vectors and streams IMG_SIZE ibuf writes, then a start pulse.
// Optional FLATTEN_TX_PERF_CNT_EN adds a saturating stall-cycle counter output.
module flatten_ibuf_tx #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_SIZE = 26,
  parameter int INPUT_CHANNELS = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH = $clog2(IMG_SIZE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic [DATA_SIZE-1:0] i_data [INPUT_CHANNELS],
  output logic o_in_ready,
  output logic [INPUT_CHANNELS-1:0] o_ibuf_we,
  output logic [DATA_SIZE-1:0] o_ibuf_data [INPUT_CHANNELS],
  input  logic i_next_ready,
  output logic o_next_start,
  output logic o_busy
`ifdef FLATTEN_TX_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, STREAM, START, WAIT_ACK} state_t;
  state_t state;
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH][INPUT_CHANNELS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic [CNT_WIDTH-1:0] cnt;
  logic empty, full, push, pop, last;
  assign empty = occ == '0;
  assign full = occ == (AW+1)'(FIFO_DEPTH);
  assign push = i_valid && !full;
  assign pop = state == STREAM && !empty;
  assign last = cnt == CNT_WIDTH'(IMG_SIZE - 1);
  assign o_in_ready = !full;
  assign o_busy = state != IDLE;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= i_data;
  // The final pop of a frame moves straight to START so writes and the pulse are back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      cnt <= '0;
      o_ibuf_we <= '0;
      o_ibuf_data <= '{default: '0};
      o_next_start <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      o_ibuf_we <= {INPUT_CHANNELS{pop}};
      if (pop) o_ibuf_data <= mem[rd_ptr];
      if (pop) cnt <= last ? '0 : cnt + CNT_WIDTH'(1);
      o_next_start <= state == START;
      state <= (state == IDLE && i_next_ready) ? STREAM :
               (pop && last) ? START :
               (state == START) ? WAIT_ACK :
               (state == WAIT_ACK && !i_next_ready) ? IDLE : state;
    end
  end
`ifdef FLATTEN_TX_PERF_CNT_EN
  logic stall;
  assign stall = (state == STREAM && empty) || (state == IDLE && !empty && !i_next_ready);
  always_ff @(posedge clk) begin
    if (rst) o_stall_cycles <= '0;
    else if (stall && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif
endmodule
